// File: rtl/div_iter_pkg.sv
// Shared types and constants for the iterative radix-2 restoring divider.
package div_iter_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } divState_e;

  // Two's-complement negate, used both for taking magnitudes and for the final sign fix.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] value);
    return ~value + WIDTH'(1);
  endfunction

  // Magnitude of an operand; only treated as signed when the operation is DIV.
  function automatic logic [WIDTH-1:0] absIfSigned(input logic [WIDTH-1:0] value,
                                                   input logic isSigned);
    return (isSigned && value[WIDTH-1]) ? negate(value) : value;
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/response bundle between the EX stage and the divider.
interface div_if;
  import div_iter_pkg::*;

  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient}; one quotient bit per cycle, MSB first.
module div_iter
  import div_iter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  divState_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   dividend_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH-1:0]   rem_q;
  logic               signedDiv_q;
  logic               dividendNeg_q;
  logic               divisorNeg_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic [WIDTH:0]     shifted_d;
  logic               qBit_d;
  logic [WIDTH-1:0]   remNext_d;
  logic [WIDTH-1:0]   quotNext_d;
  logic [WIDTH-1:0]   quotFinal_d;
  logic [WIDTH-1:0]   remFinal_d;

  // One restoring step: shift in the next dividend bit, subtract the divisor when it fits,
  // plus the sign correction applied to the last step's values when the loop finishes.
  always_comb begin
    shifted_d   = {rem_q, dividend_q[WIDTH-1]};
    qBit_d      = (shifted_d >= {1'b0, divisor_q});
    remNext_d   = qBit_d ? (shifted_d[WIDTH-1:0] - divisor_q) : shifted_d[WIDTH-1:0];
    quotNext_d  = {dividend_q[WIDTH-2:0], qBit_d};
    quotFinal_d = (signedDiv_q && (dividendNeg_q ^ divisorNeg_q)) ? negate(quotNext_d)
                                                                   : quotNext_d;
    remFinal_d  = (signedDiv_q && dividendNeg_q) ? negate(remNext_d) : remNext_d;
  end

  // Control FSM with registered result/ready; the dividend register doubles as the quotient.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= DivFree;
      cnt_q         <= '0;
      dividend_q    <= '0;
      divisor_q     <= '0;
      rem_q         <= '0;
      signedDiv_q   <= 1'b0;
      dividendNeg_q <= 1'b0;
      divisorNeg_q  <= 1'b0;
      result_q      <= '0;
      ready_q       <= 1'b0;
    end else begin
      unique case (state_q)
        DivFree: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (bus.start_i && !bus.annul_i) begin
            dividend_q    <= absIfSigned(bus.opdata1_i, bus.signed_div_i);
            divisor_q     <= absIfSigned(bus.opdata2_i, bus.signed_div_i);
            signedDiv_q   <= bus.signed_div_i;
            dividendNeg_q <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            divisorNeg_q  <= bus.signed_div_i & bus.opdata2_i[WIDTH-1];
            cnt_q         <= '0;
            rem_q         <= '0;
            state_q       <= (bus.opdata2_i == '0) ? DivByZero : DivOn;
          end
        end

        DivByZero: begin
          // Division by zero is defined to return zero; a flush still aborts it.
          if (bus.annul_i) begin
            state_q <= DivFree;
          end else begin
            result_q <= '0;
            ready_q  <= 1'b1;
            state_q  <= DivEnd;
          end
        end

        DivOn: begin
          if (bus.annul_i) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            state_q  <= DivFree;
          end else begin
            rem_q      <= remNext_d;
            dividend_q <= quotNext_d;
            cnt_q      <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
              result_q <= {remFinal_d, quotFinal_d};
              ready_q  <= 1'b1;
              state_q  <= DivEnd;
            end
          end
        end

        DivEnd: begin
          // EX may be stalled for another reason, so keep presenting the result while start holds.
          if (bus.annul_i || !bus.start_i) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            state_q  <= DivFree;
          end
        end

        default: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          state_q  <= DivFree;
        end
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
